// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern generator with FILL/BOUNCE/SCAN/COUNT modes
module led_pattern_gen #(
    parameter int LED_WIDTH     = 24,
    parameter int PRESCALE_BITS = 23
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [1:0]           mode,
    output logic [LED_WIDTH-1:0] io_led,
    output logic                 step,
    output logic                 wrap
);
    typedef enum logic [1:0] {FILL, BOUNCE, SCAN, COUNT} mode_t;
    typedef enum logic {UP, DOWN} dir_t;

    localparam logic [LED_WIDTH-1:0]     ONE     = LED_WIDTH'(1);
    localparam logic [LED_WIDTH-1:0]     ALL     = '1;
    localparam logic [PRESCALE_BITS-1:0] PRE_ONE = PRESCALE_BITS'(1);

    logic [PRESCALE_BITS-1:0] pre_q, pre_d;
    logic [LED_WIDTH-1:0]     led_q, led_d, nxt_led;
    dir_t                     dir_q, dir_d, nxt_dir;
    mode_t                    mode_q, mode_d;
    logic                     step_q, step_d, wrap_q, wrap_d, nxt_wrap;

    logic                     tick, mode_chg, all1, zero, onehot;
    logic [LED_WIDTH-1:0]     fill, sl, sr;

    assign tick     = enable && (&pre_q);
    assign mode_chg = mode != mode_q;
    assign all1     = led_q == ALL;
    assign zero     = led_q == '0;
    assign onehot   = !zero && ((led_q & (led_q - ONE)) == '0);
    assign fill     = (led_q << 1) | ONE;
    assign sl       = led_q << 1;
    assign sr       = led_q >> 1;

    // Pattern value, direction and wrap flag that a step would produce in the current mode
    always_comb begin
        nxt_led  = led_q;
        nxt_dir  = dir_q;
        nxt_wrap = 1'b0;
        case (mode_q)
            FILL: begin
                nxt_led  = all1 ? '0 : fill;
                nxt_wrap = all1;
            end
            BOUNCE: begin
                if (dir_q == UP) begin
                    nxt_led = all1 ? sr : fill;
                    nxt_dir = all1 ? DOWN : UP;
                end else begin
                    nxt_led  = zero ? ONE : sr;
                    nxt_dir  = zero ? UP : DOWN;
                    nxt_wrap = zero;
                end
            end
            SCAN: begin
                if (!onehot) begin
                    nxt_led = ONE;
                    nxt_dir = UP;
                end else if (LED_WIDTH == 1) begin
                    nxt_wrap = 1'b1;
                end else if (dir_q == UP) begin
                    nxt_led = led_q[LED_WIDTH-1] ? sr : sl;
                    nxt_dir = led_q[LED_WIDTH-1] ? DOWN : UP;
                end else begin
                    nxt_led  = led_q[0] ? sl : sr;
                    nxt_dir  = led_q[0] ? UP : DOWN;
                    nxt_wrap = led_q[0];
                end
            end
            default: begin
                nxt_led  = led_q + ONE;
                nxt_wrap = all1;
            end
        endcase
    end

    // Next register state: a mode change clears everything and beats a coincident step
    always_comb begin
        mode_d = mode_t'(mode);
        pre_d  = mode_chg ? '0 : (enable ? pre_q + PRE_ONE : pre_q);
        led_d  = mode_chg ? '0 : (tick ? nxt_led : led_q);
        dir_d  = mode_chg ? UP : (tick ? nxt_dir : dir_q);
        step_d = !mode_chg && tick;
        wrap_d = !mode_chg && tick && nxt_wrap;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            led_q  <= '0;
            dir_q  <= UP;
            mode_q <= FILL;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign io_led = led_q;
    assign step   = step_q;
    assign wrap   = wrap_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed and randomized checks of led_pattern_gen against a step-count model
module tb_led_pattern_gen;
    localparam int W      = 4;
    localparam int PB     = 2;
    localparam int PERIOD = 1 << PB;

    logic         clock, reset_n, enable;
    logic [1:0]   mode;
    logic [W-1:0] io_led;
    logic         step, wrap;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_on      = 0;

    // model state: active mode, enabled cycles within the period, steps since reset/mode change
    logic [1:0] mq;
    int         pre, n;
    bit         m_step;

    led_pattern_gen #(.LED_WIDTH(W), .PRESCALE_BITS(PB)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode),
        .io_led(io_led), .step(step), .wrap(wrap)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    // pattern after k steps from a cleared start, in closed form per mode
    function automatic logic [W-1:0] exp_led(input logic [1:0] m, input int k);
        int p, l;
        case (m)
            2'd0: return W'((1 << (k % (W + 1))) - 1);
            2'd1: begin
                p = k % (2 * W);
                l = (p <= W) ? p : 2 * W - p;
                return W'((1 << l) - 1);
            end
            2'd2: begin
                if (k == 0) return '0;
                p = (k - 1) % (2 * W - 2);
                l = (p <= W - 1) ? p : 2 * W - 2 - p;
                return W'(1 << l);
            end
            default: return W'(k % (1 << W));
        endcase
    endfunction

    function automatic bit exp_wrap(input logic [1:0] m, input int k);
        case (m)
            2'd0:    return k > 0 && k % (W + 1) == 0;
            2'd1:    return k > 1 && k % (2 * W) == 1;
            2'd2:    return k > 2 && (k - 1) % (2 * W - 2) == 1;
            default: return k > 0 && k % (1 << W) == 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mq <= 0; pre <= 0; n <= 0; m_step <= 0;
        end else if (mode != mq) begin
            mq <= mode; pre <= 0; n <= 0; m_step <= 0;
        end else if (enable) begin
            pre    <= (pre + 1) % PERIOD;
            m_step <= (pre == PERIOD - 1);
            n      <= (pre == PERIOD - 1) ? n + 1 : n;
        end else begin
            m_step <= 0;
        end
    end

    // every-cycle comparison of the DUT against the model
    always @(negedge clock) begin
        if (chk_on) begin
            chk("model io_led", io_led, exp_led(mq, n));
            chk("model step", step, m_step);
            chk("model wrap", wrap, m_step && exp_wrap(mq, n));
        end
    end

    task automatic do_reset(input logic [1:0] m);
        @(negedge clock);
        reset_n = 0;
        mode    = m;
        enable  = 1;
        @(negedge clock);
        reset_n = 1;
    endtask

    task automatic expect_step(input string nm, input logic [W-1:0] v, input bit w, input int gap);
        int c;
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!step && c < 40);
        chk({nm, " step"}, step, 1);
        chk({nm, " led"}, io_led, v);
        chk({nm, " wrap"}, wrap, w);
        if (gap > 0) chk({nm, " gap"}, c, gap);
    endtask

    initial begin
        reset_n = 0; mode = 0; enable = 0;
        @(negedge clock);
        chk_on = 1;
        chk("reset led", io_led, 0);
        chk("reset step", step, 0);
        chk("reset wrap", wrap, 0);

        // FILL, then asynchronous reset in the middle of a period
        do_reset(0);
        expect_step("fill 1", 4'b0001, 0, 4);
        expect_step("fill 2", 4'b0011, 0, 4);
        expect_step("fill 3", 4'b0111, 0, 4);
        expect_step("fill 4", 4'b1111, 0, 4);
        expect_step("fill 5", 4'b0000, 1, 4);
        expect_step("fill 6", 4'b0001, 0, 4);
        expect_step("fill 7", 4'b0011, 0, 4);
        @(negedge clock);
        #2 reset_n = 0;
        #1 chk("async reset led", io_led, 0);
        chk("async reset step", step, 0);

        // BOUNCE full cycle
        do_reset(1);
        expect_step("bounce 1", 4'b0001, 0, 5);
        expect_step("bounce 2", 4'b0011, 0, 4);
        expect_step("bounce 3", 4'b0111, 0, 4);
        expect_step("bounce 4", 4'b1111, 0, 4);
        expect_step("bounce 5", 4'b0111, 0, 4);
        expect_step("bounce 6", 4'b0011, 0, 4);
        expect_step("bounce 7", 4'b0001, 0, 4);
        expect_step("bounce 8", 4'b0000, 0, 4);
        expect_step("bounce 9", 4'b0001, 1, 4);

        // SCAN ping-pong
        do_reset(2);
        expect_step("scan 1", 4'b0001, 0, 5);
        expect_step("scan 2", 4'b0010, 0, 4);
        expect_step("scan 3", 4'b0100, 0, 4);
        expect_step("scan 4", 4'b1000, 0, 4);
        expect_step("scan 5", 4'b0100, 0, 4);
        expect_step("scan 6", 4'b0010, 0, 4);
        expect_step("scan 7", 4'b0001, 0, 4);
        expect_step("scan 8", 4'b0010, 1, 4);

        // COUNT through a full wrap
        do_reset(3);
        for (int i = 1; i <= 16; i++)
            expect_step($sformatf("count %0d", i), W'(i % 16), i == 16, (i == 1) ? 5 : 4);

        // pause with prescaler at 2
        do_reset(0);
        expect_step("pause pre", 4'b0001, 0, 4);
        repeat (2) @(negedge clock);
        enable = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("pause no step", step, 0);
            chk("pause led", io_led, 4'b0001);
        end
        enable = 1;
        expect_step("resume", 4'b0011, 0, 2);

        // mode switch coincident with a step event
        do_reset(0);
        expect_step("switch a", 4'b0001, 0, 4);
        expect_step("switch b", 4'b0011, 0, 4);
        expect_step("switch c", 4'b0111, 0, 4);
        repeat (3) @(negedge clock);
        mode = 3;
        @(negedge clock);
        chk("switch led", io_led, 0);
        chk("switch step", step, 0);
        chk("switch wrap", wrap, 0);
        expect_step("after switch", 4'b0001, 0, 4);

        // randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            enable = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 149) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                #2 reset_n = 0;
                @(negedge clock);
                reset_n = 1;
            end
        end

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
